// File: rtl/hack_screen_scanner.sv
// Scans the Hack screen memory in word order and streams one pixel per
// accepted transfer, bit 0 of each word first, with line/frame markers.
module hack_screen_scanner #(
  parameter int FRAME_WORDS = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        mem_rd,
  output logic [12:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        pixel_valid,
  output logic        pixel,
  input  logic        pixel_ready,
  output logic        pixel_sol,
  output logic        pixel_sof,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [13:0] LAST_WORD = 14'(FRAME_WORDS);

  state_t      state;
  logic [13:0] fetch_cnt;
  logic [12:0] addr_q;
  logic        rd_pending;
  logic [15:0] shift_q;
  logic [4:0]  bits_left;
  logic [12:0] shift_addr;
  logic [15:0] next_buf;
  logic [12:0] next_addr;
  logic        next_valid;

  logic xfer;
  logic load_ok;
  logic words_left;
  logic final_xfer;

  // Handshake: a pixel moves on any cycle with pixel_valid=1 and pixel_ready=1;
  // pixel, pixel_sol and pixel_sof are stable while pixel_valid=1 and pixel_ready=0.
  assign busy        = (state == SCAN);
  assign pixel_valid = (bits_left != 5'd0);
  assign pixel       = shift_q[0];
  assign pixel_sol   = (bits_left == 5'd16) && (shift_addr[4:0] == 5'd0);
  assign pixel_sof   = (bits_left == 5'd16) && (shift_addr == 13'd0);

  assign xfer       = pixel_valid && pixel_ready;
  assign load_ok    = (bits_left == 5'd0) || ((bits_left == 5'd1) && xfer);
  assign words_left = (fetch_cnt < LAST_WORD);
  assign final_xfer = xfer && (bits_left == 5'd1) && !next_valid && !rd_pending && !words_left;

  // Only one read in flight and only while the prefetch slot is free, so the
  // buffer can never be overwritten before it drains.
  assign mem_rd   = busy && !next_valid && !rd_pending && words_left;
  assign mem_addr = mem_rd ? fetch_cnt[12:0] : addr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      fetch_cnt  <= 14'd0;
      addr_q     <= 13'd0;
      rd_pending <= 1'b0;
      shift_q    <= 16'd0;
      bits_left  <= 5'd0;
      shift_addr <= 13'd0;
      next_buf   <= 16'd0;
      next_addr  <= 13'd0;
      next_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_pending <= mem_rd;
      if (mem_rd) begin
        addr_q    <= fetch_cnt[12:0];
        fetch_cnt <= fetch_cnt + 14'd1;
      end

      // addr_q still names the pending word while its data is returned.
      if (rd_pending) begin
        if (load_ok) begin
          shift_q    <= mem_data;
          bits_left  <= 5'd16;
          shift_addr <= addr_q;
        end else begin
          next_buf   <= mem_data;
          next_addr  <= addr_q;
          next_valid <= 1'b1;
          if (xfer) begin
            shift_q   <= {1'b0, shift_q[15:1]};
            bits_left <= bits_left - 5'd1;
          end
        end
      end else if (next_valid && load_ok) begin
        shift_q    <= next_buf;
        bits_left  <= 5'd16;
        shift_addr <= next_addr;
        next_valid <= 1'b0;
      end else if (xfer) begin
        shift_q   <= {1'b0, shift_q[15:1]};
        bits_left <= bits_left - 5'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            fetch_cnt <= 14'd0;
          end
        end
        SCAN: begin
          if (final_xfer) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_screen_scanner.sv
// Bench for hack_screen_scanner on a shortened 64-word frame (2 lines of
// 32 words), with a behavioural screen memory and a pixel scoreboard.
module tb_hack_screen_scanner;

  localparam int WORDS = 64;

  logic        clock;
  logic        reset;
  logic        start;
  logic        mem_rd;
  logic [12:0] mem_addr;
  logic [15:0] mem_data;
  logic        pixel_valid;
  logic        pixel;
  logic        pixel_ready;
  logic        pixel_sol;
  logic        pixel_sof;
  logic        busy;
  logic        frame_done;

  hack_screen_scanner #(.FRAME_WORDS(WORDS)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pixel_valid(pixel_valid), .pixel(pixel), .pixel_ready(pixel_ready),
    .pixel_sol(pixel_sol), .pixel_sof(pixel_sof),
    .busy(busy), .frame_done(frame_done)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] mem [0:8191];
  always @(posedge clock) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  // scoreboard state
  logic [2:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;
  int exp_rd_addr, rd_count, pix_count, words_done, sol_count;
  logic stall_prev = 1'b0;
  logic [2:0] prev_pix = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fill_mem();
    for (int w = 0; w < WORDS; w++) mem[w] = 16'($urandom_range(0, 65535));
  endtask

  task automatic begin_frame();
    exp_q.delete();
    for (int w = 0; w < WORDS; w++)
      for (int b = 0; b < 16; b++)
        exp_q.push_back({mem[w][b], (b == 0) && (w % 32 == 0), (b == 0) && (w == 0)});
    exp_rd_addr = 0; rd_count = 0; pix_count = 0; words_done = 0; sol_count = 0;
    stall_prev = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(negedge clock) begin
    logic [2:0] got;
    logic [2:0] e;
    if (mon_en) begin
      got = {pixel, pixel_sol, pixel_sof};
      if (mem_rd) begin
        chk("rd_addr", 32'(mem_addr), 32'(exp_rd_addr));
        exp_rd_addr++;
        rd_count++;
        chk("read_ahead", 32'(rd_count - words_done <= 2), 32'd1);
      end
      if (stall_prev) begin
        chk("hold_valid", 32'(pixel_valid), 32'd1);
        chk("hold_pixel", 32'(got), 32'(prev_pix));
      end
      if (pixel_valid && pixel_ready) begin
        chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pixel", 32'(got), 32'(e));
        end
        pix_count++;
        if (pix_count % 16 == 0) words_done++;
        if (pixel_sol) sol_count++;
      end
      stall_prev = pixel_valid && !pixel_ready;
      prev_pix = got;
    end
  end

  typedef struct {
    logic start;
    logic busy;
    logic rd;
    logic [12:0] addr;
    logic valid;
    logic pix;
    logic sof;
    logic sol;
  } vec_t;
  vec_t vecs[7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int k;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 13'd1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 13'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 13'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 13'd1, 1'b1, 1'b0, 1'b0, 1'b0};

    // reset overrides start
    reset = 1'b1; start = 1'b1; pixel_ready = 1'b1;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_pixel", 32'({pixel, pixel_sol, pixel_sof}), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    reset = 1'b0; start = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // frame 1: latency table, then full frame with start pulses ignored
    fill_mem();
    mem[0] = 16'h0005;
    mem[1] = 16'h8000;
    begin_frame();
    for (int i = 0; i < 7; i++) begin
      start = vecs[i].start;
      @(negedge clock);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_rd", i), 32'(mem_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(pixel_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_pix", i), 32'({pixel, pixel_sof, pixel_sol}),
          32'({vecs[i].pix, vecs[i].sof, vecs[i].sol}));
      step();
    end
    start = 1'b0;
    k = 7;
    while (!frame_done && k < 5000) begin
      start = (k == 200 || k == 500);
      step();
      k++;
    end
    start = 1'b0;
    chk("f1_done_seen", 32'(frame_done), 32'd1);
    chk("f1_done_cycle", 32'(k), 32'(3 + WORDS * 16));
    chk("f1_busy_low", 32'(busy), 32'd0);
    chk("f1_sol_count", 32'(sol_count), 32'(WORDS / 32));
    chk("f1_reads", 32'(rd_count), 32'(WORDS));
    chk("f1_queue_empty", 32'(exp_q.size()), 32'd0);

    // frame 2: restart in the frame_done cycle, random backpressure
    fill_mem();
    begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("f2_restart_rd", 32'(mem_rd), 32'd1);
    chk("f2_restart_addr", 32'(mem_addr), 32'd0);
    chk("f2_done_pulse", 32'(frame_done), 32'd0);
    k = 0;
    while (!frame_done && k < 8000) begin
      pixel_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    pixel_ready = 1'b1;
    chk("f2_done_seen", 32'(frame_done), 32'd1);
    chk("f2_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("f2_busy_low", 32'(busy), 32'd0);
    step();
    chk("f2_done_once", 32'(frame_done), 32'd0);

    // frame 3: reset with a read in flight, then rescan from word 0
    fill_mem();
    begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!(pix_count >= 600 && mem_rd) && k < 2000) begin
      step();
      k++;
    end
    chk("f3_reached", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    mon_en = 1'b0;
    step();
    reset = 1'b0;
    chk("f3_rst_busy", 32'(busy), 32'd0);
    chk("f3_rst_rd", 32'(mem_rd), 32'd0);
    chk("f3_rst_addr", 32'(mem_addr), 32'd0);
    chk("f3_rst_valid", 32'(pixel_valid), 32'd0);
    chk("f3_rst_pixel", 32'({pixel, pixel_sol, pixel_sof}), 32'd0);
    chk("f3_rst_done", 32'(frame_done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("f3_idle", 32'({busy, pixel_valid, frame_done, mem_rd}), 32'd0);
    end
    fill_mem();
    begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!frame_done && k < 5000) begin
      step();
      k++;
    end
    chk("f4_done_seen", 32'(frame_done), 32'd1);
    chk("f4_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("f4_reads", 32'(rd_count), 32'(WORDS));
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
